// File: rtl/usrt_rx_ctrl.sv
// USRT receive controller: receiver reset sequencing, byte detect, show-ahead FIFO.
// Optional stale-data timeout enabled by defining USRT_RX_CTRL_TIMEOUT_EN.
module usrt_rx_ctrl #(
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          CLOCK,
    input  logic          NRESET,
    input  logic          EN,
    input  logic          FLUSH,
    input  logic          RX_NINTI,
    input  logic [7:0]    RX_DATA,
    output logic          RX_RESET,
    output logic [7:0]    DOUT,
    output logic          DVALID,
    input  logic          DREAD,
    output logic [AW:0]   COUNT,
    output logic          OVERRUN,
    input  logic          OVR_CLR,
    output logic          TIMEOUT
);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ARM = 2'd1,
        S_RUN = 2'd2
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    state_t         r_state;
    state_t         w_next;
    logic           r_ninti_q;
    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;
    logic           r_ovr;
    logic           w_run;
    logic           w_done;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        RX_RESET = 1'b1;
        w_run    = 1'b0;
        unique case (r_state)
            S_OFF: begin
                if (EN) w_next = S_ARM;
            end
            S_ARM: begin
                w_next = EN ? S_RUN : S_OFF;
            end
            S_RUN: begin
                RX_RESET = 1'b0;
                w_run    = 1'b1;
                if (!EN)
                    w_next = S_OFF;
                else if (FLUSH)
                    w_next = S_ARM;
            end
            default: w_next = S_OFF;
        endcase
    end

    // ARM re-arms the edge detector so a stale low level cannot fake a byte.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            r_ninti_q <= 1'b1;
        end else if (r_state == S_ARM) begin
            r_ninti_q <= 1'b1;
        end else begin
            r_ninti_q <= RX_NINTI;
        end
    end

    assign w_done = w_run & ~r_ninti_q & RX_NINTI;
    assign w_full = (r_count == LP_DEPTH);
    assign DVALID = (r_count != '0);
    assign w_pop  = DVALID & DREAD & ~FLUSH;
    assign w_push = w_done & (~w_full | w_pop) & ~FLUSH;
    assign w_drop = w_done & w_full & ~w_pop & ~FLUSH;

    always_ff @(posedge CLOCK) begin
        if (w_push) r_mem[r_wr] <= RX_DATA;
    end

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (FLUSH) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (OVR_CLR) begin
            r_ovr <= 1'b0;
        end
    end

    assign DOUT    = DVALID ? r_mem[r_rd] : 8'h00;
    assign COUNT   = r_count;
    assign OVERRUN = r_ovr;

`ifdef USRT_RX_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LP_TMAX = TW'(TIMEOUT_CYC);

    logic [TW-1:0] r_tcnt;

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            r_tcnt <= '0;
        end else if (w_push || w_pop || FLUSH || !DVALID) begin
            r_tcnt <= '0;
        end else if (w_run && r_tcnt != LP_TMAX) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    assign TIMEOUT = (r_tcnt == LP_TMAX);
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule
